// File: rtl/sn76489_bus_writer.sv
// sn76489_bus_writer: turns (channel, kind, value) write requests into SN76489
// latch/data bytes and drives the ce_n/we_n/d write cycle, paced by ready_i.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for a request; d_o keeps the last byte written
// S_SETUP  | byte on d_o, strobes high, for SETUP_CYCLES cycles
// S_STROBE | ce_n/we_n low; leave once ready_i is high after MIN_STROBE
// S_HOLD   | strobes high one cycle; load second byte or finish with done
// S_ABORT  | ready never came; drop pending byte, err_o high this cycle
module sn76489_bus_writer #(
  parameter int SETUP_CYCLES = 1,
  parameter int MIN_STROBE   = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic       clk,
  input  logic       res_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_chan_i,
  input  logic       req_kind_i,
  input  logic [9:0] req_value_i,
  output logic       ce_n_o,
  output logic       we_n_o,
  output logic [0:7] d_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int CNT_MAX = (TIMEOUT > SETUP_CYCLES) ? TIMEOUT : SETUP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] MIN_LAST   = CW'(MIN_STROBE);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ABORT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_strobe_n;
  logic [7:0]      r_data;
  logic [7:0]      r_second;
  logic            r_pending;
  logic            r_done;
  logic            r_err;

  logic            w_accept;
  logic [7:0]      w_first;
  logic [7:0]      w_second;
  logic            w_two;

  // Noise carries only a 3-bit control field; tone is the only two-byte write.
  always_comb begin
    w_first  = 8'h00;
    w_second = {2'b00, req_value_i[9:4]};
    w_two    = 1'b0;
    if (req_kind_i) begin
      w_first = {1'b1, req_chan_i, 1'b1, req_value_i[3:0]};
    end else if (req_chan_i == 2'd3) begin
      w_first = {1'b1, 2'b11, 1'b0, 1'b0, req_value_i[2:0]};
    end else begin
      w_first = {1'b1, req_chan_i, 1'b0, req_value_i[3:0]};
      w_two   = 1'b1;
    end
  end

  assign req_ready_o = (r_state == S_IDLE) && !r_done && !res_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign busy_o      = (r_state != S_IDLE);
  assign ce_n_o      = r_strobe_n;
  assign we_n_o      = r_strobe_n;
  assign d_o         = r_data;
  assign done_o      = r_done;
  assign err_o       = r_err;

  always_ff @(posedge clk or posedge res_i) begin
    if (res_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_strobe_n <= 1'b1;
      r_data     <= 8'h00;
      r_second   <= 8'h00;
      r_pending  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data    <= w_first;
            r_second  <= w_second;
            r_pending <= w_two;
            r_cnt     <= CNT_ONE;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt >= SETUP_LAST) begin
            r_cnt      <= CNT_ONE;
            r_strobe_n <= 1'b0;
            r_state    <= S_STROBE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_STROBE: begin
          // ready_i is ignored until the strobe has been low MIN_STROBE cycles
          if ((r_cnt >= MIN_LAST) && ready_i) begin
            r_cnt      <= '0;
            r_strobe_n <= 1'b1;
            r_state    <= S_HOLD;
          end else if (r_cnt == TO_LAST) begin
            r_cnt      <= '0;
            r_strobe_n <= 1'b1;
            r_pending  <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= S_ABORT;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_HOLD: begin
          if (r_pending) begin
            r_data    <= r_second;
            r_pending <= 1'b0;
            r_cnt     <= CNT_ONE;
            r_state   <= S_SETUP;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_ABORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Self-checking bench for sn76489_bus_writer: table vectors, random requests
// against a byte-encoding/strobe-timing model, plus timeout, reset and b2b cases.
module tb_sn76489_bus_writer;

  localparam int SETUP_CYCLES = 1;
  localparam int MIN_STROBE   = 2;
  localparam int TIMEOUT      = 1024;
  localparam int TIMEOUT_B    = 16;

  logic       clk = 1'b0;
  logic       res = 1'b1;

  logic       valid = 1'b0;
  logic [1:0] chan  = 2'd0;
  logic       kind  = 1'b0;
  logic [9:0] value = 10'd0;
  logic       ready = 1'b1;
  logic       req_ready, ce_n, we_n, busy, done, err;
  logic [0:7] d;

  logic       valid_b = 1'b0;
  logic [1:0] chan_b  = 2'd1;
  logic       kind_b  = 1'b0;
  logic [9:0] value_b = 10'h2FE;
  logic       ready_b = 1'b0;
  logic       req_ready_b, ce_n_b, we_n_b, busy_b, done_b, err_b;
  logic [0:7] d_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sn76489_bus_writer #(
    .SETUP_CYCLES(SETUP_CYCLES), .MIN_STROBE(MIN_STROBE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .res_i(res), .req_valid_i(valid), .req_ready_o(req_ready),
    .req_chan_i(chan), .req_kind_i(kind), .req_value_i(value),
    .ce_n_o(ce_n), .we_n_o(we_n), .d_o(d), .ready_i(ready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  sn76489_bus_writer #(
    .SETUP_CYCLES(SETUP_CYCLES), .MIN_STROBE(MIN_STROBE), .TIMEOUT(TIMEOUT_B)
  ) dut_to (
    .clk(clk), .res_i(res), .req_valid_i(valid_b), .req_ready_o(req_ready_b),
    .req_chan_i(chan_b), .req_kind_i(kind_b), .req_value_i(value_b),
    .ce_n_o(ce_n_b), .we_n_o(we_n_b), .d_o(d_b), .ready_i(ready_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  typedef struct {
    logic [1:0] c;
    logic       k;
    logic [9:0] v;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding from the byte-format rules, in plain arithmetic.
  function automatic int enc(input logic [1:0] c, input logic k, input logic [9:0] v,
                             output logic [7:0] b0, output logic [7:0] b1);
    int ci, vi;
    ci = int'(c);
    vi = int'(v);
    b1 = 8'h00;
    if (k) begin
      b0 = 8'(128 + 32 * ci + 16 + vi % 16);
      return 1;
    end
    if (ci == 3) begin
      b0 = 8'(128 + 96 + vi % 8);
      return 1;
    end
    b0 = 8'(128 + 32 * ci + vi % 16);
    b1 = 8'(vi / 16);
    return 2;
  endfunction

  // mode 0: ready tied high; 1: ready low for 32 cycles of each strobe; 2: random ready
  task automatic run_req(input logic [1:0] c, input logic k, input logic [9:0] v, input int mode,
                         output int nb, output logic [7:0] g0, output logic [7:0] g1,
                         output int lat);
    logic [7:0] e0, e1, cur;
    int en, len, ndone, nerr, w;
    bit prev_low, exp_end, fin;
    en = enc(c, k, v, e0, e1);
    nb = 0; g0 = 8'h00; g1 = 8'h00; lat = -1; ndone = 0; nerr = 0; len = 0;
    cur = 8'h00; prev_low = 1'b0; exp_end = 1'b0; fin = 1'b0;
    @(negedge clk);
    valid = 1'b1; chan = c; kind = k; value = v; ready = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", req_ready, 1);
    @(negedge clk);
    valid = 1'b0; chan = ~c; kind = ~k; value = ~v;
    for (int i = 0; i < 3000 && !fin; i++) begin
      if (i > 0) @(negedge clk);
      chk("ce_we_pair", we_n, ce_n);
      if (prev_low) chk("strobe_end_rule", ce_n, exp_end);
      if (!ce_n) begin
        if (!prev_low) begin
          cur = d;
          len = 1;
          if (nb == 0) g0 = cur; else g1 = cur;
          nb++;
        end else begin
          len++;
          chk("d_stable", d, cur);
        end
      end else if (prev_low && mode != 2) begin
        chk("strobe_len", len, (mode == 0) ? MIN_STROBE : 33);
      end
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ce_n ? 1'b1 : (len >= 33);
        default: ready = ($urandom_range(0, 2) != 0);
      endcase
      exp_end  = !ce_n && ((len >= MIN_STROBE && ready) || len == TIMEOUT);
      prev_low = !ce_n;
      if (err) begin
        nerr++;
        fin = 1'b1;
      end
      if (done) begin
        ndone++;
        lat = i;
        fin = 1'b1;
        chk("ready_blocked_on_done", req_ready, 0);
        chk("busy_after_done", busy, 0);
      end
    end
    ready = 1'b1;
    chk("byte_count", nb, en);
    chk("byte0", g0, e0);
    if (en == 2) chk("byte1", g1, e1);
    chk("done_count", ndone, 1);
    chk("err_count", nerr, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, lat, w, lowc, asserts, ne, nd, bad_d, a1, a2, done1, ndone_bb;
    logic [7:0] g0, g1;
    logic [7:0] q[$];
    bit prevl;

    tbl[0] = '{2'd1, 1'b0, 10'h2FE, 2, 8'hAE, 8'h2F};
    tbl[1] = '{2'd2, 1'b1, 10'h005, 1, 8'hD5, 8'h00};
    tbl[2] = '{2'd3, 1'b0, 10'h004, 1, 8'hE4, 8'h00};
    tbl[3] = '{2'd0, 1'b0, 10'h3FF, 2, 8'h8F, 8'h3F};
    tbl[4] = '{2'd3, 1'b1, 10'h00F, 1, 8'hFF, 8'h00};
    tbl[5] = '{2'd3, 1'b0, 10'h3FF, 1, 8'hE7, 8'h00};
    tbl[6] = '{2'd0, 1'b1, 10'h3F0, 1, 8'h90, 8'h00};
    tbl[7] = '{2'd2, 1'b0, 10'h001, 2, 8'hC1, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ce_n", ce_n, 1);
    chk("rst_we_n", we_n, 1);
    chk("rst_d", d, 8'h00);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    res = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);

    // Table vectors with ready tied high
    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].c, tbl[i].k, tbl[i].v, 0, nb, g0, g1, lat);
      chk("tbl_nbytes", nb, tbl[i].n);
      chk("tbl_b0", g0, tbl[i].b0);
      if (tbl[i].n == 2) chk("tbl_b1", g1, tbl[i].b1);
      chk("tbl_latency", lat, (tbl[i].n == 2) ? 8 : 4);
    end
    chk("idle_d_retained", d, 8'h00);

    // Slow PSG: ready low for 32 cycles of each strobe
    run_req(2'd1, 1'b0, 10'h2FE, 1, nb, g0, g1, lat);
    chk("slow_b0", g0, 8'hAE);
    chk("slow_b1", g1, 8'h2F);
    chk("slow_latency", lat, 70);

    // Randomized requests with random ready
    for (int i = 0; i < 30; i++) begin
      run_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              10'($urandom_range(0, 1023)), 2, nb, g0, g1, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Timeout on the TIMEOUT=16 instance with ready stuck low
    @(negedge clk);
    ready_b = 1'b0; valid_b = 1'b1;
    w = 0;
    while (!req_ready_b && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("to_accept_wait", req_ready_b, 1);
    @(negedge clk);
    valid_b = 1'b0; chan_b = 2'd0; value_b = 10'h000;
    lowc = 0; asserts = 0; ne = 0; nd = 0; bad_d = 0; prevl = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!ce_n_b) begin
        lowc++;
        if (!prevl) asserts++;
        if (d_b != 8'hAE) bad_d++;
      end
      if (ce_n_b != we_n_b) bad_d++;
      if (err_b) ne++;
      if (done_b) nd++;
      prevl = !ce_n_b;
      @(negedge clk);
    end
    chk("to_low_cycles", lowc, TIMEOUT_B);
    chk("to_strobe_count", asserts, 1);
    chk("to_bad_bus", bad_d, 0);
    chk("to_err_pulses", ne, 1);
    chk("to_done_pulses", nd, 0);
    chk("to_busy_fell", busy_b, 0);
    chk("to_req_ready", req_ready_b, 1);
    chk("to_d_no_second", d_b, 8'hAE);

    // Reset in the middle of the first strobe of a tone write
    @(negedge clk);
    valid = 1'b1; chan = 2'd0; kind = 1'b0; value = 10'h123; ready = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    w = 0;
    while (ce_n && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("rm_strobe_seen", ce_n, 0);
    @(negedge clk);
    #1 res = 1'b1;
    #1;
    chk("rm_ce_n_async", ce_n, 1);
    chk("rm_we_n_async", we_n, 1);
    chk("rm_busy", busy, 0);
    chk("rm_req_ready_in_rst", req_ready, 0);
    @(negedge clk);
    res = 1'b0;
    ready = 1'b1;
    ne = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (err) ne++;
      if (done) nd++;
    end
    chk("rm_req_ready", req_ready, 1);
    chk("rm_no_err", ne, 0);
    chk("rm_no_done", nd, 0);
    chk("rm_d_cleared", d, 8'h00);

    // Back-to-back requests with valid held high
    @(negedge clk);
    ready = 1'b1; valid = 1'b1; chan = 2'd1; kind = 1'b0; value = 10'h2FE;
    a1 = -1; a2 = -1; done1 = -1; ndone_bb = 0; prevl = 1'b0;
    q.delete();
    for (int i = 0; i < 80 && ndone_bb < 2; i++) begin
      if (i > 0) @(negedge clk);
      if (!ce_n && !prevl) q.push_back(d);
      prevl = !ce_n;
      if (a1 >= 0 && i == a1 + 1) begin
        chan = 2'd2; kind = 1'b1; value = 10'h005;
      end
      if (a2 >= 0 && i == a2 + 1) valid = 1'b0;
      if (done) begin
        ndone_bb++;
        if (done1 < 0) done1 = i;
        chk("bb_no_accept_on_done", req_ready, 0);
      end
      if (valid && req_ready) begin
        if (a1 < 0) a1 = i;
        else if (a2 < 0) a2 = i;
      end
    end
    valid = 1'b0;
    chk("bb_done_count", ndone_bb, 2);
    chk("bb_second_accept", a2, done1 + 1);
    chk("bb_nbytes", q.size(), 3);
    if (q.size() == 3) begin
      chk("bb_b0", q[0], 8'hAE);
      chk("bb_b1", q[1], 8'h2F);
      chk("bb_b2", q[2], 8'hD5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sn76489_bus_writer.md
Name: sn76489_bus_writer

Overview:
Host-side bus master for the sn76489 PSG core. It accepts abstract register-write requests (channel, kind, value), encodes them into SN76489 latch/data bytes and drives the chip's ce_n/we_n/d write cycle. Each byte is paced by the chip's ready handshake. It sits between the test sequencer or CPU model and the DUT pins, and is the write-side counterpart of the sn76489 interface.

Parameters:
SETUP_CYCLES, 1, clk cycles data is driven with strobes high before strobe assertion (>=1)
MIN_STROBE, 2, minimum clk cycles ce_n/we_n held low before ready is sampled (>=1)
TIMEOUT, 1024, max clk cycles in strobe phase waiting for ready before abort (> MIN_STROBE)

Ports:
clk  in  1  system clock, all logic on rising edge
res_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready on a clk edge
req_chan_i  in  2  channel 0..2 tone, 3 noise
req_kind_i  in  1  0 = tone/noise control, 1 = attenuation
req_value_i  in  10  payload (tone period / noise ctrl [2:0] / attenuation [3:0])
ce_n_o  out  1  chip enable to PSG, active low
we_n_o  out  1  write enable to PSG, active low
d_o  out  [0:7]  data bus, d_o[0] = MSB (chip D0 numbering)
ready_i  in  1  PSG ready, high = idle/write accepted
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse when a request completes successfully
err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, immediate): ce_n_o=1, we_n_o=1, d_o=8'h00, req_ready_o=0 while res_i high, busy_o=0, done_o=0, err_o=0, state IDLE, all counters 0.
- req_ready_o = 1 only in IDLE and not in reset. Request fields are captured on acceptance; later input changes are ignored.
- Encoding, with L = latch byte {1, chan[1:0], kind, nibble[3:0]}:
  - Tone (chan 0..2, kind 0): two bytes. First L with nibble = value[3:0], then data byte {0, 0, value[9:4]}.
  - Noise (chan 3, kind 0): one byte L with nibble = {0, value[2:0]}.
  - Attenuation (kind 1, any chan): one byte L with nibble = value[3:0].
  - Unused value bits are ignored.
- FSM states and transitions:
  - IDLE: on accept, go to SETUP. d_o = first byte.
  - SETUP: strobes high, d_o stable. After SETUP_CYCLES cycles, go to STROBE.
  - STROBE: ce_n_o=0 and we_n_o=0 in the same cycle, d_o stable. Cycle counter starts at 1 on entry.
    - If counter >= MIN_STROBE and ready_i=1, go to HOLD.
    - Else if counter == TIMEOUT, go to ABORT.
    - Ready is not sampled before MIN_STROBE.
  - HOLD: strobes high, d_o held for exactly 1 cycle.
    - If a second byte is pending, load it into d_o and go to SETUP.
    - Otherwise pulse done_o and go to IDLE.
  - ABORT: strobes high, pending second byte discarded, err_o pulses for 1 cycle, go to IDLE.
- ce_n_o and we_n_o always change together. d_o never changes while strobes are low.
- d_o retains the last byte in IDLE.
- Minimum single-byte latency, from accept edge to done_o: SETUP_CYCLES + MIN_STROBE + 1 cycles.
- ready_i is used directly, with no synchroniser (same clk domain as the PSG model). A low-then-high ready sequence is not required; ready high at the first sample point ends the strobe.
- Reset mid-operation: strobes deassert asynchronously and the request is lost. No done_o or err_o is generated.
- A new request cannot be accepted in the cycle done_o or err_o pulses. It can be accepted from the following cycle.

Test Plan:
- Tone ch1, value 10'h2FE, ready_i tied 1, defaults -> d_o=8'hAE during first strobe, 8'h2F during second. Each strobe low exactly 2 cycles. done_o pulses once, 8 cycles after accept.
- Attenuation ch2, value 4'h5 -> single strobe with d_o=8'hD5, done_o pulse. Noise ch3, value 3'h4 -> single strobe with d_o=8'hE4.
- PSG holds ready_i low for 32 cycles after strobe assertion -> strobes stay low until the cycle after ready_i rises. d_o stable throughout. No err_o.
- ready_i stuck low, TIMEOUT=16, tone request -> strobes low exactly 16 cycles, err_o pulses once, second byte never driven, done_o never pulses, busy_o falls.
- res_i asserted mid-strobe of a tone request's first byte -> ce_n_o/we_n_o go high in the same cycle without waiting for a clk edge. After release, IDLE with req_ready_o=1 and no done_o/err_o.
- Back-to-back requests with req_valid_i held high -> second accept occurs no earlier than the cycle after done_o. Input changes after the first accept do not alter the bytes driven.
